datard: RTL and testbench
=========================

Name: datard

Overview:
- Read-side counterpart of the packet write path. Given a packet's start address and length, fetches the words from the packet SRAM and streams them out to one output port with valid/ready flow control, marking sop and eop.
- Sits between the output scheduler, which issues start pulses, and the SRAM read port, which has fixed 1-cycle read latency.
- Holds a 2-entry output FIFO, so backpressure never drops SRAM data.

Parameters:
- sg_data_width, 64, SRAM word / output data width
- sg_address_width, 12, SRAM word address width
- sg_len_width, 8, packet length field width, in words
- sg_des_width, 4, destination port tag width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  one-cycle request to read a packet
- start_address  input  sg_address_width  first word address of the packet
- length  input  sg_len_width  packet length in words
- des_port_in  input  sg_des_width  destination tag, forwarded with the packet
- busy  output  1  packet in progress; start is ignored while high
- rd_en  output  1  SRAM read strobe
- rd_address  output  sg_address_width  SRAM read address
- rd_data  input  sg_data_width  SRAM read data, valid the cycle after rd_en
- out_valid  output  1  out_data holds a word
- out_ready  input  1  sink accepts the word
- out_data  output  sg_data_width  packet word
- out_sop  output  1  first word of the packet, qualified by out_valid
- out_eop  output  1  last word of the packet, qualified by out_valid
- out_des_port  output  sg_des_width  latched des_port_in for the current packet
- done  output  1  one-cycle pulse after the eop word is accepted

Behaviour:
- Reset (rst=0): takes effect immediately and asynchronously.
  - All outputs go to 0, the FIFO empties, and the state returns to IDLE.
  - Any in-flight SRAM read is discarded and its rd_data is not captured.
- State machine has two states, IDLE and READ.
- IDLE:
  - busy=0.
  - start=1 with length!=0: latch start_address, length and des_port_in; clear the issue and send counters; next state is READ.
  - start=1 with length=0: ignored. No done, no outputs.
- READ:
  - busy=1. A start pulse in this state is ignored.
  - An SRAM read is issued (rd_en=1, registered) when both conditions hold:
    - issued < length
    - FIFO occupancy + reads in flight − (pop this cycle) < 2
  - rd_address = base + issued, modulo 2^sg_address_width. The address wraps from all-ones to 0.
  - rd_data is pushed into the FIFO the cycle after rd_en. The credit rule guarantees the FIFO never overflows.
  - out_valid = FIFO not empty, and out_data = FIFO head.
  - A pop occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_sop and out_eop are held stable.
  - out_sop=1 when the word index being sent is 0.
  - out_eop=1 when the word index being sent is length−1. For length=1, sop and eop are high on the same beat.
  - On the eop pop: in the next cycle done=1 for one cycle, busy=0 and state is IDLE. A start in that cycle is accepted.
- Latency and throughput:
  - start sampled at edge T0: rd_en at T1, FIFO push at T2, out_valid from T2.
  - With out_ready held at 1, one word is sent per cycle and rd_en stays high for length consecutive cycles.
- Length arithmetic:
  - The issue and send counters are sg_len_width+1 bits wide, so the maximum length (2^sg_len_width − 1) completes correctly.
- out_des_port is constant from start acceptance until the eop pop.

Test Plan:
- Basic packet: start_address=0x010, length=4, out_ready=1.
  - rd_address 0x010, 0x011, 0x012, 0x013 on consecutive rd_en cycles.
  - Words D0..D3 appear in order; sop on D0, eop on D3.
  - done pulses exactly once; busy falls with done.
- Backpressure: length=6, out_ready forced low for 3 cycles after word 1.
  - Never more than 2 words buffered plus in flight.
  - out_data holds D1 stable while stalled.
  - All 6 words arrive in order with no loss or duplication.
- Address wrap: start_address=0xFFE, length=4.
  - rd_address sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Single word and ignored starts:
  - length=1 gives one beat with sop=eop=1.
  - length=0 produces no activity.
  - A start issued while busy=1 does not change rd_address or out_des_port.
- Reset mid-packet: rst driven to 0 during word 2 of a length=8 packet.
  - All outputs are 0 in the same cycle.
  - After rst returns to 1, a new start (address 0x100, length 2) completes cleanly.
- Back-to-back packets: start asserted in the done cycle of packet A.
  - Packet B's rd_en begins the following cycle.
  - B's sop and des_port are correct.

Source files
------------

// File: rtl/datard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// datard_if : scheduler, SRAM read port and output stream signals of datard
// Revision  : 1.0
// ---------------------------------------------------------------------------
interface datard_if #(
  parameter int sg_data_width    = 64,
  parameter int sg_address_width = 12,
  parameter int sg_len_width     = 8,
  parameter int sg_des_width     = 4
) ();
  logic                        start;
  logic [sg_address_width-1:0] start_address;
  logic [sg_len_width-1:0]     length;
  logic [sg_des_width-1:0]     des_port_in;
  logic                        busy;
  logic                        rd_en;
  logic [sg_address_width-1:0] rd_address;
  logic [sg_data_width-1:0]    rd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [sg_data_width-1:0]    out_data;
  logic                        out_sop;
  logic                        out_eop;
  logic [sg_des_width-1:0]     out_des_port;
  logic                        done;

  modport master (
    input  start, start_address, length, des_port_in, rd_data, out_ready,
    output busy, rd_en, rd_address, out_valid, out_data, out_sop, out_eop,
           out_des_port, done
  );

  modport slave (
    output start, start_address, length, des_port_in, rd_data, out_ready,
    input  busy, rd_en, rd_address, out_valid, out_data, out_sop, out_eop,
           out_des_port, done
  );
endinterface
`default_nettype wire

// File: rtl/datard.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// datard   : streams a packet from the packet SRAM to one valid/ready port
// Revision : 1.0
// ---------------------------------------------------------------------------
module datard #(
  parameter int sg_data_width    = 64,
  parameter int sg_address_width = 12,
  parameter int sg_len_width     = 8,
  parameter int sg_des_width     = 4
) (
  input  logic      clk,
  input  logic      rst,
  datard_if.master  bus
);

  localparam logic [sg_len_width:0] len_one = (sg_len_width+1)'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                      state;
  logic                        busy_q;
  logic                        done_q;
  logic                        rd_en_q;
  logic                        rd_vld;
  logic [sg_address_width-1:0] base;
  logic [sg_address_width-1:0] rd_addr_q;
  logic [sg_len_width:0]       len_q;
  logic [sg_len_width:0]       issued;
  logic [sg_len_width:0]       sent;
  logic [sg_des_width-1:0]     des_q;

  logic [sg_data_width-1:0]    mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  count;

  logic                        out_valid_w;
  logic [sg_data_width-1:0]    head;
  logic                        pop;
  logic                        bypass;
  logic                        push;
  logic                        fifo_pop;
  logic                        last;
  logic [2:0]                  outstanding;
  logic [2:0]                  after_pop;
  logic                        issue;

  // Returning SRAM data falls straight through to the output when the FIFO
  // is empty, so the first word is visible in the cycle it arrives.
  assign out_valid_w = (count != 2'd0) || rd_vld;
  assign head        = (count != 2'd0) ? mem[rd_ptr] : bus.rd_data;
  assign pop         = out_valid_w && bus.out_ready;
  assign bypass      = (count == 2'd0) && pop;
  assign push        = rd_vld && !bypass;
  assign fifo_pop    = pop && (count != 2'd0);
  assign last        = (sent == (len_q - len_one));

  // Credits cover stored words, the word arriving now and the read in flight.
  assign outstanding = {1'b0, count} + {2'b00, rd_vld} + {2'b00, rd_en_q};
  assign after_pop   = outstanding - {2'b00, pop};
  assign issue       = (state == READ) && (issued < len_q) && (after_pop < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_vld    <= 1'b0;
      base      <= '0;
      rd_addr_q <= '0;
      len_q     <= '0;
      issued    <= '0;
      sent      <= '0;
      des_q     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= issue;
      rd_vld  <= rd_en_q;

      if (issue) begin
        rd_addr_q <= base + sg_address_width'(issued);
        issued    <= issued + len_one;
      end

      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, fifo_pop};

      case (state)
        IDLE: begin
          if (bus.start && (bus.length != '0)) begin
            base   <= bus.start_address;
            len_q  <= {1'b0, bus.length};
            des_q  <= bus.des_port_in;
            issued <= '0;
            sent   <= '0;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          if (pop) begin
            sent <= sent + len_one;
            if (last) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rd_data;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_address   = rd_addr_q;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_data     = out_valid_w ? head : '0;
  assign bus.out_sop      = out_valid_w && (sent == '0);
  assign bus.out_eop      = out_valid_w && last;
  assign bus.out_des_port = des_q;
  assign bus.done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_datard.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_datard : directed checks of datard against a behavioural SRAM
// Revision  : 1.0
// ---------------------------------------------------------------------------
module tb_datard;

  localparam int DW   = 64;
  localparam int AW   = 12;
  localparam int LW   = 8;
  localparam int DESW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  datard_if #(.sg_data_width(DW), .sg_address_width(AW),
              .sg_len_width(LW), .sg_des_width(DESW)) bus ();

  datard #(.sg_data_width(DW), .sg_address_width(AW),
           .sg_len_width(LW), .sg_des_width(DESW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] word(input logic [11:0] a);
    return {20'hABCDE, a, 20'h12345, a};
  endfunction

  // SRAM: data valid the cycle after rd_en, garbage otherwise
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? word(bus.rd_address) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  logic [63:0] beat_data [$];
  logic        beat_sop  [$];
  logic        beat_eop  [$];
  logic [3:0]  beat_des  [$];
  logic [11:0] addr_q    [$];
  int done_cnt, issued_cnt, accepted_cnt, max_out;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rd_en) begin
        addr_q.push_back(bus.rd_address);
        issued_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_data.push_back(bus.out_data);
        beat_sop.push_back(bus.out_sop);
        beat_eop.push_back(bus.out_eop);
        beat_des.push_back(bus.out_des_port);
        accepted_cnt++;
      end
      if (bus.done) done_cnt++;
      if (issued_cnt - accepted_cnt > max_out) max_out = issued_cnt - accepted_cnt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beat_data.delete(); beat_sop.delete(); beat_eop.delete(); beat_des.delete();
    addr_q.delete();
    done_cnt = 0; issued_cnt = 0; accepted_cnt = 0; max_out = 0;
  endtask

  task automatic send_start(input logic [11:0] a, input logic [7:0] l, input logic [3:0] d);
    bus.start_address = a;
    bus.length        = l;
    bus.des_port_in   = d;
    bus.start         = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    chk({tag, " done seen"}, 64'(found), 64'd1);
    if (found) chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_pkt(input string tag, input int idx0, input logic [11:0] base,
                           input int n, input logic [3:0] des);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      if (idx0 + i < addr_q.size())
        chk({tag, " rd_address"}, 64'(addr_q[idx0+i]), 64'(a));
      else
        chk({tag, " rd_address missing"}, 64'(addr_q.size()), 64'(idx0 + i + 1));
      if (idx0 + i < beat_data.size()) begin
        chk({tag, " data"}, beat_data[idx0+i], word(a));
        chk({tag, " sop"},  64'(beat_sop[idx0+i]), 64'(i == 0));
        chk({tag, " eop"},  64'(beat_eop[idx0+i]), 64'(i == n - 1));
        chk({tag, " des"},  64'(beat_des[idx0+i]), 64'(des));
      end else begin
        chk({tag, " beat missing"}, 64'(beat_data.size()), 64'(idx0 + i + 1));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start         = 1'b0;
    bus.start_address = '0;
    bus.length        = '0;
    bus.des_port_in   = '0;
    bus.out_ready     = 1'b1;
    clear_mon();

    // reset state
    repeat (3) @(negedge clk);
    chk("reset busy",      64'(bus.busy),         64'd0);
    chk("reset rd_en",     64'(bus.rd_en),        64'd0);
    chk("reset out_valid", 64'(bus.out_valid),    64'd0);
    chk("reset out_data",  bus.out_data,          64'd0);
    chk("reset done",      64'(bus.done),         64'd0);
    chk("reset des",       64'(bus.out_des_port), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1 clear_mon();

    // basic packet with latency checks
    send_start(12'h010, 8'd4, 4'h3);
    @(negedge clk);
    chk("basic T0 busy",      64'(bus.busy),      64'd1);
    chk("basic T0 rd_en",     64'(bus.rd_en),     64'd0);
    @(negedge clk);
    chk("basic T1 rd_en",     64'(bus.rd_en),     64'd1);
    chk("basic T1 rd_addr",   64'(bus.rd_address), 64'h010);
    chk("basic T1 out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("basic T2 out_valid", 64'(bus.out_valid), 64'd1);
    chk("basic T2 out_data",  bus.out_data,       word(12'h010));
    chk("basic T2 sop",       64'(bus.out_sop),   64'd1);
    chk("basic T2 des",       64'(bus.out_des_port), 64'h3);
    wait_done(20, "basic");
    repeat (3) @(negedge clk);
    #1;
    chk("basic beats", 64'(beat_data.size()), 64'd4);
    check_pkt("basic", 0, 12'h010, 4, 4'h3);
    chk("basic done count", 64'(done_cnt), 64'd1);

    // backpressure while D1 is presented
    clear_mon();
    send_start(12'h020, 8'd6, 4'h6);
    repeat (3) @(negedge clk);
    chk("bp D0 data", bus.out_data, word(12'h020));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp stall valid", 64'(bus.out_valid), 64'd1);
      chk("bp stall data",  bus.out_data,       word(12'h021));
      chk("bp stall sop",   64'(bus.out_sop),   64'd0);
      if (s >= 1) chk("bp stall rd_en", 64'(bus.rd_en), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(30, "bp");
    repeat (2) @(negedge clk);
    #1;
    chk("bp beats", 64'(beat_data.size()), 64'd6);
    check_pkt("bp", 0, 12'h020, 6, 4'h6);
    chk("bp outstanding<=2", 64'(max_out <= 2), 64'd1);

    // address wrap
    clear_mon();
    send_start(12'hFFE, 8'd4, 4'h1);
    wait_done(20, "wrap");
    repeat (2) @(negedge clk);
    #1;
    chk("wrap beats", 64'(beat_data.size()), 64'd4);
    check_pkt("wrap", 0, 12'hFFE, 4, 4'h1);

    // single word
    clear_mon();
    send_start(12'h050, 8'd1, 4'h2);
    wait_done(10, "single");
    repeat (2) @(negedge clk);
    #1;
    chk("single beats", 64'(beat_data.size()), 64'd1);
    check_pkt("single", 0, 12'h050, 1, 4'h2);

    // zero length is ignored
    clear_mon();
    send_start(12'h060, 8'd0, 4'h7);
    repeat (8) @(negedge clk);
    #1;
    chk("zero reads", 64'(addr_q.size()),    64'd0);
    chk("zero beats", 64'(beat_data.size()), 64'd0);
    chk("zero done",  64'(done_cnt),         64'd0);
    chk("zero busy",  64'(bus.busy),         64'd0);

    // start while busy is ignored
    clear_mon();
    send_start(12'h200, 8'd4, 4'h5);
    @(negedge clk);
    send_start(12'h300, 8'd3, 4'h9);
    wait_done(20, "busy-start");
    repeat (4) @(negedge clk);
    #1;
    chk("busy-start reads", 64'(addr_q.size()),    64'd4);
    chk("busy-start beats", 64'(beat_data.size()), 64'd4);
    check_pkt("busy-start", 0, 12'h200, 4, 4'h5);
    chk("busy-start done count", 64'(done_cnt), 64'd1);

    // asynchronous reset during word 2
    clear_mon();
    send_start(12'h040, 8'd8, 4'h4);
    repeat (5) @(negedge clk);
    chk("rstmid D2 data", bus.out_data, word(12'h042));
    #2 rst = 1'b0;
    #1;
    chk("rstmid busy",      64'(bus.busy),         64'd0);
    chk("rstmid rd_en",     64'(bus.rd_en),        64'd0);
    chk("rstmid out_valid", 64'(bus.out_valid),    64'd0);
    chk("rstmid out_data",  bus.out_data,          64'd0);
    chk("rstmid sop",       64'(bus.out_sop),      64'd0);
    chk("rstmid eop",       64'(bus.out_eop),      64'd0);
    chk("rstmid des",       64'(bus.out_des_port), 64'd0);
    chk("rstmid rd_addr",   64'(bus.rd_address),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 clear_mon();
    send_start(12'h100, 8'd2, 4'h8);
    wait_done(15, "post-reset");
    repeat (2) @(negedge clk);
    #1;
    chk("post-reset beats", 64'(beat_data.size()), 64'd2);
    check_pkt("post-reset", 0, 12'h100, 2, 4'h8);

    // back-to-back: B started in A's done cycle
    clear_mon();
    send_start(12'h300, 8'd3, 4'h3);
    wait_done(15, "b2b A");
    send_start(12'h380, 8'd2, 4'hA);
    @(negedge clk);
    chk("b2b B T0 busy",  64'(bus.busy),  64'd1);
    chk("b2b B T0 rd_en", 64'(bus.rd_en), 64'd0);
    @(negedge clk);
    chk("b2b B T1 rd_en",   64'(bus.rd_en),      64'd1);
    chk("b2b B T1 rd_addr", 64'(bus.rd_address), 64'h380);
    wait_done(15, "b2b B");
    repeat (2) @(negedge clk);
    #1;
    chk("b2b beats", 64'(beat_data.size()), 64'd5);
    check_pkt("b2b A", 0, 12'h300, 3, 4'h3);
    check_pkt("b2b B", 3, 12'h380, 2, 4'hA);
    chk("b2b done count", 64'(done_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
